// File: rtl/seq_divider_6by3_pkg.sv
// Shared widths and state encoding for the sequential 6-by-3 restoring divider.
package seq_divider_6by3_pkg;

  localparam int unsigned DIVIDEND_W = 6;
  localparam int unsigned DIVISOR_W  = 3;
  localparam int unsigned CNT_W      = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/seq_divider_6by3_if.sv
// Request/result bundle for the divider: start handshake, operands and registered results.
interface seq_divider_6by3_if;
  import seq_divider_6by3_pkg::*;

  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  ready;
  logic                  valid;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  ready, valid, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output ready, valid, quotient, remainder, div_by_zero
  );

endinterface

// File: rtl/seq_divider_6by3_div_step.sv
// One restoring-division step: shift in the next dividend bit, compare, conditionally subtract.
module div_step
  import seq_divider_6by3_pkg::*;
(
  input  logic [DIVISOR_W:0]   rem_in,
  input  logic                 bit_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W:0]   rem_out,
  output logic                 qbit
);

  logic [DIVISOR_W:0] t;

  always_comb begin
    t       = {rem_in[DIVISOR_W-1:0], bit_in};
    // rem_in MSB is always zero (remainder < divisor); folding it in keeps the step total.
    qbit    = rem_in[DIVISOR_W] || (t >= {1'b0, divisor});
    rem_out = qbit ? (t - {1'b0, divisor}) : t;
  end

endmodule

// File: rtl/seq_divider_6by3.sv
// Sequential restoring divider: 6-bit dividend / 3-bit divisor, one quotient bit per clock.
module seq_divider_6by3
  import seq_divider_6by3_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  seq_divider_6by3_if.slave bus
);

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q;
  logic [DIVIDEND_W-1:0] shift_q;
  logic [DIVIDEND_W-2:0] quot_q;
  logic [DIVISOR_W-1:0]  divisor_q;
  logic [DIVISOR_W:0]    rem_q, rem_next;
  logic [DIVIDEND_W-1:0] quotient_q;
  logic [DIVISOR_W-1:0]  remainder_q;
  logic                  dbz_q;
  logic                  qbit;
  logic                  accept, last_iter;

  div_step u_step (
    .rem_in  (rem_q),
    .bit_in  (shift_q[DIVIDEND_W-1]),
    .divisor (divisor_q),
    .rem_out (rem_next),
    .qbit    (qbit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    last_iter = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          accept  = 1'b1;
          state_d = (bus.divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (cnt_q == CNT_W'(DIVIDEND_W - 1)) begin
          last_iter = 1'b1;
          state_d   = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // quot_q holds one bit fewer than the quotient; the last qbit joins it on the load into quotient_q.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q       <= '0;
      shift_q     <= '0;
      quot_q      <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      dbz_q       <= 1'b0;
    end else if (accept) begin
      shift_q   <= bus.dividend;
      divisor_q <= bus.divisor;
      rem_q     <= '0;
      cnt_q     <= '0;
      quot_q    <= '0;
      if (bus.divisor == '0) begin
        quotient_q  <= '1;
        remainder_q <= '0;
        dbz_q       <= 1'b1;
      end
    end else if (state_q == RUN) begin
      shift_q <= shift_q << 1;
      rem_q   <= rem_next;
      quot_q  <= {quot_q[DIVIDEND_W-3:0], qbit};
      cnt_q   <= cnt_q + CNT_W'(1);
      if (last_iter) begin
        quotient_q  <= {quot_q, qbit};
        remainder_q <= rem_next[DIVISOR_W-1:0];
        dbz_q       <= 1'b0;
      end
    end
  end

  assign bus.ready       = (state_q == IDLE);
  assign bus.valid       = (state_q == DONE);
  assign bus.quotient    = quotient_q;
  assign bus.remainder   = remainder_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_divider_6by3.sv
// Self-checking bench for seq_divider_6by3: cycle model compare plus directed and random operations.
module tb_seq_divider_6by3;
  import seq_divider_6by3_pkg::*;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  seq_divider_6by3_if bus ();

  seq_divider_6by3 dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;

  // Model: m_left counts cycles until the result cycle (1 = valid cycle, 0 = idle).
  int       m_left = 0;
  logic [5:0] m_q = '0, p_q = '0;
  logic [2:0] m_r = '0, p_r = '0;
  logic       m_z = 1'b0, p_z = 1'b0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_left = 0; m_q = '0; m_r = '0; m_z = 1'b0;
    end
    vectors++;
    if ({bus.ready, bus.valid, bus.quotient, bus.remainder, bus.div_by_zero} !==
        {m_left == 0, m_left == 1, m_q, m_r, m_z}) begin
      errors++;
      $display("FAIL cycle_check t=%0t got rdy=%b vld=%b q=%0d r=%0d dz=%b, expected rdy=%b vld=%b q=%0d r=%0d dz=%b",
               $time, bus.ready, bus.valid, bus.quotient, bus.remainder, bus.div_by_zero,
               m_left == 0, m_left == 1, m_q, m_r, m_z);
    end
    if (rst_n) begin
      if (m_left == 0 && bus.start === 1'b1) begin
        if (bus.divisor == 0) begin
          p_q = 6'd63; p_r = 3'd0; p_z = 1'b1; m_left = 1;
        end else begin
          p_q = bus.dividend / bus.divisor;
          p_r = bus.dividend % bus.divisor;
          p_z = 1'b0; m_left = 7;
        end
      end else if (m_left > 0) begin
        m_left--;
      end
      if (m_left == 1) begin
        m_q = p_q; m_r = p_r; m_z = p_z;
      end
    end
  end

  task automatic check(input string name, input int got, input int exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic do_op(input logic [5:0] a, input logic [2:0] b,
                       output logic [5:0] q, output logic [2:0] r,
                       output logic z, output int lat);
    int k;
    @(posedge clk); #2;
    k = 0;
    while (!bus.ready && k < 20) begin
      @(posedge clk); #2;
      k++;
    end
    if (!bus.ready) begin
      vectors++; errors++;
      $display("FAIL ready_timeout got ready=0 expected 1");
    end
    bus.start = 1'b1; bus.dividend = a; bus.divisor = b;
    @(posedge clk); #2;
    bus.start = 1'b0;
    bus.dividend = 6'($urandom);
    bus.divisor  = 3'($urandom);
    lat = 0; q = '0; r = '0; z = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        lat = i; q = bus.quotient; r = bus.remainder; z = bus.div_by_zero;
        break;
      end
    end
    if (lat == 0) begin
      vectors++; errors++;
      $display("FAIL valid_timeout a=%0d b=%0d got no valid expected one within 20", a, b);
    end
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [5:0] q, prod;
    logic [2:0] r, q3;
    logic       z;
    int         lat, v1, v2, nv;
    int ta[6] = '{63, 0, 5, 49, 13, 6};
    int tb[6] = '{1, 7, 7, 7, 0, 3};
    int tq[6] = '{63, 0, 0, 7, 63, 2};
    int tr[6] = '{0, 0, 5, 0, 0, 0};
    int tz[6] = '{0, 0, 0, 0, 1, 0};
    int tl[6] = '{7, 7, 7, 7, 1, 7};

    bus.start = 1'b0; bus.dividend = '0; bus.divisor = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset_ready", bus.ready, 1);
    check("reset_valid", bus.valid, 0);
    check("reset_quot",  bus.quotient, 0);
    check("reset_rem",   bus.remainder, 0);
    check("reset_dbz",   bus.div_by_zero, 0);
    rst_n = 1'b1;

    do_op(6'd42, 3'd5, q, r, z, lat);
    check("op42_5_q", q, 8);
    check("op42_5_r", r, 2);
    check("op42_5_dbz", z, 0);
    check("op42_5_lat", lat, 7);

    for (int i = 0; i < 6; i++) begin
      do_op(6'(ta[i]), 3'(tb[i]), q, r, z, lat);
      check($sformatf("tbl%0d_q", i), q, tq[i]);
      check($sformatf("tbl%0d_r", i), r, tr[i]);
      check($sformatf("tbl%0d_dbz", i), z, tz[i]);
      check($sformatf("tbl%0d_lat", i), lat, tl[i]);
    end

    // Second start during RUN must be ignored.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = 6'd20; bus.divisor = 3'd3;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    bus.start = 1'b1; bus.dividend = 6'd50; bus.divisor = 3'd2;
    @(posedge clk); #2;
    bus.start = 1'b0;
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        nv = 1;
        check("ignored_start_q", bus.quotient, 6);
        check("ignored_start_r", bus.remainder, 2);
        break;
      end
    end
    check("ignored_start_valid_seen", nv, 1);

    // Start held high: consecutive results 8 cycles apart.
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = 6'd30; bus.divisor = 3'd4;
    v1 = -1; v2 = -1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (bus.valid) begin
        check("b2b_q", bus.quotient, 7);
        check("b2b_r", bus.remainder, 2);
        if (v1 < 0) v1 = i;
        else if (v2 < 0) v2 = i;
      end
    end
    check("b2b_spacing", v2 - v1, 8);
    @(posedge clk); #2;
    bus.start = 1'b0;

    // Reset at iteration 3 aborts the operation.
    do_op(6'd45, 3'd6, q, r, z, lat);
    @(posedge clk); #2;
    bus.start = 1'b1; bus.dividend = 6'd45; bus.divisor = 3'd6;
    @(posedge clk); #2;
    bus.start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("abort_ready", bus.ready, 1);
    check("abort_valid", bus.valid, 0);
    check("abort_quot",  bus.quotient, 0);
    check("abort_rem",   bus.remainder, 0);
    check("abort_dbz",   bus.div_by_zero, 0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    do_op(6'd45, 3'd6, q, r, z, lat);
    check("post_abort_q", q, 7);
    check("post_abort_r", r, 3);
    check("post_abort_lat", lat, 7);

    for (int a = 0; a < 64; a++) begin
      for (int b = 1; b < 8; b++) begin
        do_op(6'(a), 3'(b), q, r, z, lat);
        check("sweep_q", q, a / b);
        check("sweep_roundtrip", int'(q) * b + int'(r), a);
        check("sweep_rem_lt", int'(r < 3'(b)), 1);
        if (q < 8) begin
          q3   = q[2:0];
          prod = q3 * 3'(b);
          check("sweep_mul3", int'(prod) + int'(r), a);
        end
      end
    end

    for (int n = 0; n < 60; n++) begin
      int a, b;
      a = $urandom_range(0, 63);
      b = $urandom_range(0, 7);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      do_op(6'(a), 3'(b), q, r, z, lat);
      check("rand_q",   q,   (b == 0) ? 63 : a / b);
      check("rand_r",   r,   (b == 0) ? 0  : a % b);
      check("rand_dbz", z,   (b == 0) ? 1  : 0);
      check("rand_lat", lat, (b == 0) ? 1  : 7);
    end

    repeat (3) @(posedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
